// File: rtl/minibyte_bus_arb_pkg.sv
// rtl/minibyte_bus_arb_pkg.sv - shared state encodings and counter width for the bus arbiter
package minibyte_bus_arb_pkg;

  localparam int ARB_STATE_W = 2;
  localparam int CNT_W       = 4;

  typedef enum logic [ARB_STATE_W-1:0] {
    ARB_CPU    = 2'd0,
    ARB_DRAIN  = 2'd1,
    ARB_HOST   = 2'd2,
    ARB_RETURN = 2'd3
  } arb_state_t;

  function automatic logic cnt_param_ok(input int v);
    return (v >= 1) && (v <= 15);
  endfunction

endpackage

// File: rtl/minibyte_bus_arb_if.sv
// rtl/minibyte_bus_arb_if.sv - CPU, host and external bus signals of the arbiter
interface minibyte_bus_arb_if;
  import minibyte_bus_arb_pkg::*;

  logic [7:0]             cpu_addr_in;
  logic [7:0]             cpu_data_in;
  logic                   cpu_we_in;
  logic                   cpu_drive_in;
  logic                   cpu_ena_out;
  logic                   host_req_in;
  logic [7:0]             host_addr_in;
  logic [7:0]             host_wdata_in;
  logic                   host_we_in;
  logic                   host_gnt_out;
  logic                   host_rvalid_out;
  logic [7:0]             host_rdata_out;
  logic [7:0]             mem_data_in;
  logic [7:0]             mem_addr_out;
  logic [7:0]             mem_data_out;
  logic                   mem_we_out;
  logic                   mem_drive_out;
  logic [ARB_STATE_W-1:0] arb_state_out;

  modport slave (
    input  cpu_addr_in, cpu_data_in, cpu_we_in, cpu_drive_in,
    input  host_req_in, host_addr_in, host_wdata_in, host_we_in,
    input  mem_data_in,
    output cpu_ena_out, host_gnt_out, host_rvalid_out, host_rdata_out,
    output mem_addr_out, mem_data_out, mem_we_out, mem_drive_out,
    output arb_state_out
  );

  modport master (
    output cpu_addr_in, cpu_data_in, cpu_we_in, cpu_drive_in,
    output host_req_in, host_addr_in, host_wdata_in, host_we_in,
    output mem_data_in,
    input  cpu_ena_out, host_gnt_out, host_rvalid_out, host_rdata_out,
    input  mem_addr_out, mem_data_out, mem_we_out, mem_drive_out,
    input  arb_state_out
  );

endinterface

// File: rtl/minibyte_bus_arb_fsm.sv
// rtl/minibyte_bus_arb_fsm.sv - ownership FSM with burst limit and CPU slot guarantee
module minibyte_bus_arb_fsm
  import minibyte_bus_arb_pkg::*;
#(
  parameter int HOST_MAX_BURST = 4,
  parameter int CPU_MIN_SLOTS  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_req,
  output arb_state_t state,
  output logic       cpu_ena,
  output logic       host_gnt
);

  localparam logic [CNT_W-1:0] MAX_BURST = CNT_W'(HOST_MAX_BURST);
  localparam logic [CNT_W-1:0] MIN_SLOTS = CNT_W'(CPU_MIN_SLOTS);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] slot_cnt;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ARB_CPU;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_CPU:    if (host_req && (slot_cnt == '0)) state_d = ARB_DRAIN;
      ARB_DRAIN:  state_d = ARB_HOST;
      ARB_HOST:   if (!host_req || (burst_cnt == MAX_BURST - 4'd1)) state_d = ARB_RETURN;
      ARB_RETURN: state_d = ARB_CPU;
      default:    state_d = ARB_CPU;
    endcase
  end

  // cpu_ena tracks the next state so the CPU is stalled exactly while it is not the owner
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
      slot_cnt  <= MIN_SLOTS;
      cpu_ena   <= 1'b1;
    end else begin
      case (state_q)
        ARB_CPU:    if (slot_cnt != '0) slot_cnt <= slot_cnt - 4'd1;
        ARB_DRAIN:  burst_cnt <= '0;
        ARB_HOST:   if (host_req) burst_cnt <= burst_cnt + 4'd1;
        ARB_RETURN: slot_cnt <= MIN_SLOTS;
        default:    ;
      endcase
      cpu_ena <= (state_d == ARB_CPU);
    end
  end

  always_comb begin
    host_gnt = 1'b0;
    if (!rst && (state_q == ARB_HOST) && host_req) host_gnt = 1'b1;
  end

  assign state = state_q;

endmodule

// File: rtl/minibyte_bus_arb.sv
// rtl/minibyte_bus_arb.sv - shares the external 8-bit bus between the CPU and a host requester
module minibyte_bus_arb
  import minibyte_bus_arb_pkg::*;
#(
  parameter int HOST_MAX_BURST = 4,
  parameter int CPU_MIN_SLOTS  = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  minibyte_bus_arb_if.slave   bus
);

  if (!cnt_param_ok(HOST_MAX_BURST) || !cnt_param_ok(CPU_MIN_SLOTS)) begin : g_param_check
    $error("minibyte_bus_arb: HOST_MAX_BURST and CPU_MIN_SLOTS must be in 1..15");
  end

  arb_state_t state;
  logic       cpu_ena;
  logic       host_gnt;

  minibyte_bus_arb_fsm #(
    .HOST_MAX_BURST (HOST_MAX_BURST),
    .CPU_MIN_SLOTS  (CPU_MIN_SLOTS)
  ) u_fsm (
    .clk      (clk_in),
    .rst      (rst_in),
    .host_req (bus.host_req_in),
    .state    (state),
    .cpu_ena  (cpu_ena),
    .host_gnt (host_gnt)
  );

  assign bus.cpu_ena_out   = cpu_ena;
  assign bus.host_gnt_out  = host_gnt;
  assign bus.arb_state_out = state;

  // Turnaround states and idle HOST cycles park the bus at all-zero
  always_comb begin
    bus.mem_addr_out  = '0;
    bus.mem_data_out  = '0;
    bus.mem_we_out    = 1'b0;
    bus.mem_drive_out = 1'b0;
    if (state == ARB_CPU) begin
      bus.mem_addr_out  = bus.cpu_addr_in;
      bus.mem_data_out  = bus.cpu_data_in;
      bus.mem_we_out    = bus.cpu_we_in;
      bus.mem_drive_out = bus.cpu_drive_in;
    end else if ((state == ARB_HOST) && bus.host_req_in) begin
      bus.mem_addr_out  = bus.host_addr_in;
      bus.mem_data_out  = bus.host_wdata_in;
      bus.mem_we_out    = bus.host_we_in;
      bus.mem_drive_out = bus.host_we_in;
    end
    if (rst_in) bus.mem_we_out = 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bus.host_rvalid_out <= 1'b0;
      bus.host_rdata_out  <= '0;
    end else begin
      bus.host_rvalid_out <= host_gnt && !bus.host_we_in;
      if (host_gnt && !bus.host_we_in) bus.host_rdata_out <= bus.mem_data_in;
    end
  end

endmodule

// File: tb/tb_minibyte_bus_arb.sv
// tb/tb_minibyte_bus_arb.sv - scoreboard bench for minibyte_bus_arb
module tb_minibyte_bus_arb;
  import minibyte_bus_arb_pkg::*;

  typedef struct packed {
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  string      cur = "init";
  beat_t      beat_q[$];
  logic [7:0] rd_q[$];
  int         exp_st[$];
  int         exp_gn[$];

  minibyte_bus_arb_if bus();

  minibyte_bus_arb #(
    .HOST_MAX_BURST (4),
    .CPU_MIN_SLOTS  (2)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // Memory model: read data is the address xor 0xDA (0x80 -> 0x5A)
  assign bus.mem_data_in = bus.mem_addr_out ^ 8'hDA;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s c=%0d: got %0h expected %0h", cur, nm, cyc, act, exp);
    end
  endtask

  task automatic monitor();
    beat_t      b;
    logic [7:0] r;
    forever begin
      @(negedge clk);
      if (bus.host_gnt_out === 1'b1) begin
        if (beat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s unexpected_gnt c=%0d: got gnt at addr %0h expected none", cur, cyc, bus.mem_addr_out);
        end else begin
          b = beat_q.pop_front();
          chk("beat_addr", bus.mem_addr_out, b.addr);
          chk("beat_we", bus.mem_we_out, b.we);
          chk("beat_drive", bus.mem_drive_out, b.we);
          chk("beat_wdata", bus.mem_data_out, b.wdata);
        end
      end
      if (bus.host_rvalid_out === 1'b1) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s unexpected_rvalid c=%0d: got rdata %0h expected no rvalid", cur, cyc, bus.host_rdata_out);
        end else begin
          r = rd_q.pop_front();
          chk("rdata", bus.host_rdata_out, r);
        end
      end
    end
  endtask

  task automatic do_reset();
    cur = "reset";
    rst = 1'b1;
    bus.host_req_in   = 1'b1;
    bus.host_addr_in  = 8'hFF;
    bus.host_wdata_in = 8'hFF;
    bus.host_we_in    = 1'b1;
    bus.cpu_addr_in   = 8'h55;
    bus.cpu_data_in   = 8'hAA;
    bus.cpu_we_in     = 1'b1;
    bus.cpu_drive_in  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_state", bus.arb_state_out, ARB_CPU);
    chk("rst_ena", bus.cpu_ena_out, 1);
    chk("rst_rvalid", bus.host_rvalid_out, 0);
    chk("rst_rdata", bus.host_rdata_out, 0);
    chk("rst_gnt", bus.host_gnt_out, 0);
    chk("rst_mem_we", bus.mem_we_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run(input int nb, input logic [7:0] base, input logic we,
                     input int req_from, input int rst_at, input logic sweep,
                     input logic [7:0] cpu_a, input logic [7:0] cpu_d, input logic cw);
    int idx;
    idx = 0;
    for (int i = 0; i < nb; i++) begin
      logic [7:0] a;
      a = base + 8'(i);
      beat_q.push_back(beat_t'{a, we, a + 8'h40});
      if (!we) rd_q.push_back(a ^ 8'hDA);
    end
    for (int c = 0; c < exp_st.size(); c++) begin
      logic [7:0] ca;
      ca  = sweep ? 8'(c) : cpu_a;
      cyc = c;
      rst = (c == rst_at);
      bus.cpu_addr_in   = ca;
      bus.cpu_data_in   = cpu_d;
      bus.cpu_we_in     = cw;
      bus.cpu_drive_in  = cw;
      bus.host_req_in   = (c >= req_from) && (idx < nb);
      bus.host_addr_in  = base + 8'(idx);
      bus.host_wdata_in = base + 8'(idx) + 8'h40;
      bus.host_we_in    = we;
      @(negedge clk);
      chk("state", bus.arb_state_out, exp_st[c]);
      chk("gnt", bus.host_gnt_out, exp_gn[c]);
      chk("cpu_ena", bus.cpu_ena_out, (exp_st[c] == 0) ? 1 : 0);
      if (c == rst_at) begin
        chk("mem_we_in_reset", bus.mem_we_out, 0);
      end else if (exp_st[c] == 0) begin
        chk("pass_addr", bus.mem_addr_out, ca);
        chk("pass_data", bus.mem_data_out, cpu_d);
        chk("pass_we", bus.mem_we_out, cw);
        chk("pass_drive", bus.mem_drive_out, cw);
      end else if (exp_gn[c] == 0) begin
        chk("mask_addr", bus.mem_addr_out, 0);
        chk("mask_data", bus.mem_data_out, 0);
        chk("mask_we", bus.mem_we_out, 0);
        chk("mask_drive", bus.mem_drive_out, 0);
      end
      if ((rst_at >= 0) && (c == rst_at + 1)) chk("rvalid_after_rst", bus.host_rvalid_out, 0);
      if (bus.host_gnt_out === 1'b1) idx++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish after 200000 time units, expected completion");
    $fatal(1);
  end

  initial begin
    fork
      monitor();
    join_none

    do_reset();
    cur = "cpu_sweep";
    exp_st.delete();
    exp_gn.delete();
    for (int i = 0; i < 16; i++) begin
      exp_st.push_back(0);
      exp_gn.push_back(0);
    end
    run(0, 8'h00, 1'b0, 0, -1, 1'b1, 8'h00, 8'h3C, 1'b0);

    do_reset();
    cur = "host_read";
    exp_st = '{0, 0, 0, 1, 2, 2, 3, 0};
    exp_gn = '{0, 0, 0, 0, 1, 0, 0, 0};
    run(1, 8'h80, 1'b0, 0, -1, 1'b0, 8'h01, 8'h02, 1'b0);

    do_reset();
    cur = "burst_limit";
    exp_st = '{0, 0, 0, 1, 2, 2, 2, 2, 3, 0, 0, 0, 1, 2, 2, 2, 2, 3, 0};
    exp_gn = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    run(8, 8'h10, 1'b1, 0, -1, 1'b0, 8'h04, 8'h08, 1'b0);

    do_reset();
    cur = "early_drop";
    exp_st = '{0, 0, 0, 1, 2, 2, 2, 3, 0};
    exp_gn = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
    run(2, 8'h30, 1'b1, 0, -1, 1'b0, 8'h77, 8'h66, 1'b1);

    do_reset();
    cur = "reset_mid_burst";
    exp_st = '{0, 0, 0, 1, 2, 2, 2, 0, 0, 0, 1, 2, 2, 3, 0};
    exp_gn = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    run(3, 8'h40, 1'b0, 0, 6, 1'b0, 8'h09, 8'h0A, 1'b0);

    do_reset();
    cur = "cpu_write";
    exp_st = '{0, 0, 0, 1, 2, 2, 3, 0};
    exp_gn = '{0, 0, 0, 0, 1, 0, 0, 0};
    run(1, 8'h90, 1'b1, 2, -1, 1'b0, 8'h20, 8'hA5, 1'b1);

    cur = "end";
    chk("beat_q_left", beat_q.size(), 0);
    chk("rd_q_left", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
